// File: rtl/keypad_entry.sv
// 4x3 key matrix scanner with per-scan debounce, decoding and decimal-to-binary
// digit entry. '*' clears the entry, '#' commits it to VALUE.
module keypad_entry #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int MAX_DIGITS     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  KEY_ROW,
    output logic [2:0]  KEY_COL,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_PULSE,
    output logic [31:0] ENTRY_VALUE,
    output logic        ENTRY_FULL,
    output logic [31:0] VALUE,
    output logic        VALID
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [3:0] CODE_NONE  = 4'hF;
    localparam logic [3:0] CODE_MULTI = 4'hE;
    localparam logic [3:0] CODE_STAR  = 4'd10;
    localparam logic [3:0] CODE_HASH  = 4'd11;

    typedef enum logic {RELEASED, PRESSED} state_t;

    state_t            state, state_nxt;
    logic [3:0]        row_p0, row_p1;
    logic [DIV_W-1:0]  dwell;
    logic [1:0]        col;
    logic [1:0]        acc_cnt;
    logic [3:0]        acc_code;
    logic [3:0]        prev_result;
    logic [DB_W-1:0]   stable_cnt, stable_nxt;
    logic [DB_W-1:0]   rel_cnt, rel_nxt;
    logic [3:0]        digit_cnt, digit_nxt;
    logic [31:0]       entry_nxt;
    logic              accept, commit;

    logic              sample, scan_done, result_is_key;
    logic [3:0]        low;
    logic [2:0]        low_n, low_sum;
    logic [1:0]        base_cnt, scan_cnt;
    logic [3:0]        base_code, scan_code, result;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        if (r == 2'd3) begin
            case (c)
                2'd0:    k = CODE_STAR;
                2'd1:    k = 4'd0;
                default: k = CODE_HASH;
            endcase
        end else begin
            k = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        end
        return k;
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign KEY_COL = (col == 2'd0) ? 3'b110 : (col == 2'd1) ? 3'b101 : 3'b011;

    // Per-column contribution to the scan result; accumulation restarts at column 0.
    always_comb begin
        sample    = (dwell == DIV_W'(SCAN_DIV - 1));
        scan_done = sample && (col == 2'd2);
        low       = ~row_p1;
        low_n     = ones4(low);
        base_cnt  = (col == 2'd0) ? 2'd0 : acc_cnt;
        base_code = (col == 2'd0) ? CODE_NONE : acc_code;
        low_sum   = {1'b0, base_cnt} + low_n;
        scan_cnt  = (low_sum > 3'd1) ? 2'd2 : low_sum[1:0];
        scan_code = (base_cnt == 2'd0 && low_n == 3'd1) ? key_map(first_low(low), col) : base_code;
        result    = (scan_cnt == 2'd0) ? CODE_NONE :
                    (scan_cnt == 2'd1) ? scan_code : CODE_MULTI;
        result_is_key = (result < 4'd12);
    end

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        rel_nxt    = rel_cnt;
        accept     = 1'b0;
        if (scan_done) begin
            case (state)
                RELEASED: begin
                    if (result_is_key && result == prev_result)
                        stable_nxt = stable_cnt + DB_W'(1);
                    else
                        stable_nxt = result_is_key ? DB_W'(1) : '0;
                    if (stable_nxt == DB_W'(DEBOUNCE_SCANS)) begin
                        accept     = 1'b1;
                        state_nxt  = PRESSED;
                        stable_nxt = '0;
                    end
                end
                default: begin
                    rel_nxt = (result == CODE_NONE) ? rel_cnt + DB_W'(1) : '0;
                    if (rel_nxt == DB_W'(DEBOUNCE_SCANS)) begin
                        state_nxt = RELEASED;
                        rel_nxt   = '0;
                    end
                end
            endcase
        end
    end

    // x*10 + d as shift-add keeps the datapath free of a multiplier.
    always_comb begin
        entry_nxt = ENTRY_VALUE;
        digit_nxt = digit_cnt;
        commit    = 1'b0;
        if (accept) begin
            if (result <= 4'd9) begin
                if (digit_cnt < 4'(MAX_DIGITS)) begin
                    entry_nxt = (ENTRY_VALUE << 3) + (ENTRY_VALUE << 1) + {28'd0, result};
                    digit_nxt = digit_cnt + 4'd1;
                end
            end else if (result == CODE_STAR) begin
                entry_nxt = '0;
                digit_nxt = '0;
            end else if (result == CODE_HASH) begin
                commit    = 1'b1;
                entry_nxt = '0;
                digit_nxt = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= RELEASED;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_p0      <= 4'hF;
            row_p1      <= 4'hF;
            dwell       <= '0;
            col         <= 2'd0;
            acc_cnt     <= 2'd0;
            acc_code    <= CODE_NONE;
            prev_result <= CODE_NONE;
            stable_cnt  <= '0;
            rel_cnt     <= '0;
            KEY_CODE    <= CODE_NONE;
            KEY_PULSE   <= 1'b0;
            ENTRY_VALUE <= '0;
            digit_cnt   <= '0;
            ENTRY_FULL  <= 1'b0;
            VALUE       <= '0;
            VALID       <= 1'b0;
        end else begin
            row_p0 <= KEY_ROW;
            row_p1 <= row_p0;
            if (sample) begin
                dwell    <= '0;
                col      <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                acc_cnt  <= scan_cnt;
                acc_code <= scan_code;
            end else begin
                dwell <= dwell + DIV_W'(1);
            end
            if (scan_done) prev_result <= result;
            stable_cnt  <= stable_nxt;
            rel_cnt     <= rel_nxt;
            KEY_PULSE   <= accept;
            if (accept) KEY_CODE <= result;
            ENTRY_VALUE <= entry_nxt;
            digit_cnt   <= digit_nxt;
            ENTRY_FULL  <= (digit_nxt == 4'(MAX_DIGITS));
            VALID       <= commit;
            if (commit) VALUE <= ENTRY_VALUE;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: key presses held for whole scans, checked against a
// scan-level model of debounce and decimal entry.
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int MD = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic [31:0] entry_value;
    logic        entry_full;
    logic [31:0] value;
    logic        valid;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .MAX_DIGITS(MD)) dut (
        .CLK(CLK), .RST(RST), .KEY_ROW(key_row), .KEY_COL(key_col),
        .KEY_CODE(key_code), .KEY_PULSE(key_pulse), .ENTRY_VALUE(entry_value),
        .ENTRY_FULL(entry_full), .VALUE(value), .VALID(valid)
    );

    always #5 CLK = ~CLK;

    // bit k of keys = key with code k held down
    logic [11:0] keys = '0;

    function automatic int krow(input int k);
        if (k == 0 || k >= 10) return 3;
        return (k - 1) / 3;
    endfunction

    function automatic int kcol(input int k);
        if (k == 0) return 1;
        if (k == 10) return 0;
        if (k == 11) return 2;
        return (k - 1) % 3;
    endfunction

    always_comb begin
        key_row = 4'hF;
        for (int k = 0; k < 12; k++)
            if (keys[k] && !key_col[kcol(k)]) key_row[krow(k)] = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // expected outputs for the first cycle of the next scan
    logic        exp_pulse, exp_valid, exp_full;
    logic [3:0]  exp_code;
    logic [31:0] exp_entry, exp_value;
    int m_pressed, m_run, m_rel, m_prev, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [2:0] col_pat(input int c);
        return (c == 0) ? 3'b110 : (c == 1) ? 3'b101 : 3'b011;
    endfunction

    task automatic model_reset();
        exp_pulse = 0; exp_valid = 0; exp_full = 0;
        exp_code = 4'hF; exp_entry = 0; exp_value = 0;
        m_pressed = 0; m_run = 0; m_rel = 0; m_prev = -1; m_cnt = 0;
    endtask

    task automatic model_accept(input int k);
        exp_pulse = 1;
        exp_code  = 4'(k);
        if (k <= 9) begin
            if (m_cnt < MD) begin
                exp_entry = exp_entry * 10 + k;
                m_cnt++;
            end
        end else if (k == 10) begin
            exp_entry = 0; m_cnt = 0;
        end else begin
            exp_value = exp_entry; exp_valid = 1;
            exp_entry = 0; m_cnt = 0;
        end
        exp_full = (m_cnt == MD);
    endtask

    // result: -1 nothing pressed, -2 several keys, otherwise the key code
    task automatic model_scan(input logic [11:0] mask);
        int n, res;
        n = $countones(mask);
        res = (n == 0) ? -1 : (n > 1) ? -2 : 0;
        if (n == 1)
            for (int k = 0; k < 12; k++) if (mask[k]) res = k;
        exp_pulse = 0;
        exp_valid = 0;
        if (m_pressed == 0) begin
            m_run = (res >= 0 && res == m_prev) ? m_run + 1 : (res >= 0 ? 1 : 0);
            if (m_run >= DB) begin
                model_accept(res);
                m_pressed = 1;
                m_run = 0;
            end
        end else begin
            m_rel = (res == -1) ? m_rel + 1 : 0;
            if (m_rel >= DB) begin
                m_pressed = 0;
                m_rel = 0;
            end
        end
        m_prev = res;
    endtask

    // Called at the falling edge of the first cycle of a scan (column 0, dwell 0).
    task automatic do_scan(input logic [11:0] mask);
        chk("key_col_start", key_col, 3'b110);
        chk("key_pulse", key_pulse, exp_pulse);
        chk("valid", valid, exp_valid);
        chk("key_code", key_code, exp_code);
        chk("entry_value", entry_value, exp_entry);
        chk("value", value, exp_value);
        chk("entry_full", entry_full, exp_full);
        if (key_pulse) pulses++;
        keys = mask;
        for (int i = 1; i < 3 * SD; i++) begin
            @(negedge CLK);
            chk("key_col", key_col, col_pat(i / SD));
            chk("pulse_quiet", key_pulse, 1'b0);
            chk("valid_quiet", valid, 1'b0);
        end
        @(negedge CLK);
        model_scan(mask);
    endtask

    task automatic scans(input logic [11:0] mask, input int n);
        for (int i = 0; i < n; i++) do_scan(mask);
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int          key;
        int          hold;
        int          npulse;
        logic [31:0] entry;
        logic [31:0] val;
        logic        full;
    } vec_t;

    vec_t tbl[15];

    task automatic run_vec(input int i);
        int p0;
        p0 = pulses;
        scans(12'(1) << tbl[i].key, tbl[i].hold);
        scans('0, DB + 2);
        chk($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'(tbl[i].npulse));
        chk($sformatf("vec%0d_entry", i), entry_value, tbl[i].entry);
        chk($sformatf("vec%0d_value", i), value, tbl[i].val);
        chk($sformatf("vec%0d_full", i), {31'd0, entry_full}, {31'd0, tbl[i].full});
    endtask

    initial begin
        int p0, ent;
        logic [11:0] m;
        tbl[0] = '{1, 4, 1, 1, 0, 0};
        tbl[1] = '{2, 4, 1, 12, 0, 0};
        tbl[2] = '{3, 4, 1, 123, 0, 0};
        tbl[3] = '{11, 11, 1, 0, 123, 0};
        ent = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < MD) ent = ent * 10 + 9;
            tbl[4 + i] = '{9, 3, 1, 32'(ent), 123, (i >= MD - 1)};
        end
        tbl[13] = '{10, 3, 1, 0, 123, 0};
        tbl[14] = '{4, 3, 1, 4, 123, 0};

        keys = '0;
        model_reset();
        apply_reset();
        chk("rst_key_col", key_col, 3'b110);
        chk("rst_key_code", key_code, 4'hF);
        chk("rst_entry", entry_value, 0);
        chk("rst_value", value, 0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_pulse", key_pulse, 1'b0);
        scans('0, 2);

        for (int i = 0; i < 4; i++) run_vec(i);

        // single-scan press followed by a bouncing contact
        p0 = pulses;
        do_scan(12'(1) << 5);
        for (int i = 0; i < 6; i++) do_scan((i % 2 == 0) ? 12'd0 : 12'(1) << 5);
        scans('0, DB + 2);
        chk("bounce_pulses", 32'(pulses - p0), 0);
        chk("bounce_entry", entry_value, 0);

        for (int i = 4; i < 14; i++) run_vec(i);

        // two keys at once
        p0 = pulses;
        scans((12'(1) << 5) | (12'(1) << 6), 5);
        scans('0, DB + 2);
        chk("multi_pulses", 32'(pulses - p0), 0);

        run_vec(14);

        // reset in the middle of debouncing '7'
        do_scan(12'(1) << 7);
        apply_reset();
        chk("midrst_entry", entry_value, 0);
        chk("midrst_code", key_code, 4'hF);
        p0 = pulses;
        scans(12'(1) << 7, DB);
        chk("midrst_no_early", 32'(pulses - p0), 0);
        scans('0, DB + 2);
        chk("midrst_one_pulse", 32'(pulses - p0), 1);
        chk("midrst_code7", key_code, 4'd7);
        chk("midrst_entry7", entry_value, 7);

        // random key activity against the model
        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) m = '0;
            else if (sel == 1) m = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
            else m = 12'(1) << $urandom_range(0, 11);
            scans(m, int'($urandom_range(1, 4)));
            scans('0, int'($urandom_range(0, 3)));
        end
        scans('0, DB + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Scans a 4x3 telephone-style key matrix, debounces key presses and decodes them.
- Accumulates decimal digits into a binary value, i.e. decimal-to-binary entry. This is the input-side counterpart of the display path.
- ENTRY_VALUE is intended to drive the display controller's BINARY_SCORE directly; committed values go to game/control logic.
- Single clock domain; the matrix row inputs are asynchronous.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (1 ms at 1 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press or a release; must be >= 1.
- MAX_DIGITS, 8: maximum digits held in the entry buffer; must be <= 9.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- KEY_ROW  in  4  matrix rows, active-low, externally pulled up, asynchronous
- KEY_COL  out  3  matrix column drive, active-low, exactly one bit low at any time
- KEY_CODE  out  4  last accepted key code
- KEY_PULSE  out  1  one-cycle strobe per accepted key press
- ENTRY_VALUE  out  32  binary value of the digits entered so far (live)
- ENTRY_FULL  out  1  high when the digit count equals MAX_DIGITS
- VALUE  out  32  last committed value
- VALID  out  1  one-cycle strobe when VALUE is updated

Behaviour:
- Reset (synchronous): KEY_COL=3'b110; KEY_CODE=4'hF; ENTRY_VALUE=0; VALUE=0; all strobes and flags 0; all counters and synchronizers cleared; FSM=RELEASED.
- Reset takes effect on the next CLK edge from any state, including mid-press, and discards any partial entry.
- Key map by (row, column):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Key codes: digits 0-9 as themselves, '*'=10, '#'=11, none=15.
- KEY_ROW passes through a 2-flop synchronizer before any use.
- Scan: a dwell counter runs 0..SCAN_DIV-1 per column. On wrap the column advances 0->1->2->0 (KEY_COL 110->101->011->110).
- Synchronized rows are sampled on the last dwell cycle (count == SCAN_DIV-1).
- Per-scan result, built over columns 0..2 and evaluated when column 2 is sampled:
  - NONE: no low row bits.
  - KEY k: exactly one low row bit across all three columns.
  - MULTI: two or more low bits.
- Debounce FSM, evaluated once per completed scan:
  - RELEASED: if the result is KEY k and equals the previous scan's result, stable_cnt increments; otherwise stable_cnt is set to 1 for a KEY result, or 0 for NONE/MULTI. When stable_cnt reaches DEBOUNCE_SCANS: accept k, go to PRESSED, clear stable_cnt.
  - PRESSED: if the result is NONE, rel_cnt increments; any other result clears rel_cnt. When rel_cnt reaches DEBOUNCE_SCANS: go to RELEASED.
  - A held key produces exactly one acceptance. No auto-repeat.
- Acceptance timing:
  - KEY_PULSE=1 for exactly one cycle, on the cycle after the column-2 sample that completes the debounce.
  - KEY_CODE is updated on the same edge and holds until the next acceptance.
- Action on acceptance, registered on the same edge as KEY_PULSE:
  - Digit d with count < MAX_DIGITS: ENTRY_VALUE <= ENTRY_VALUE*10 + d, computed as (x<<3)+(x<<1)+d in 32 bits; count increments. Leading zeros count as digits.
  - Digit d with count == MAX_DIGITS: ignored (KEY_PULSE still fires); ENTRY_VALUE unchanged.
  - '*': ENTRY_VALUE <= 0; count <= 0.
  - '#': VALUE <= ENTRY_VALUE; VALID=1 for one cycle, coincident with KEY_PULSE; ENTRY_VALUE <= 0; count <= 0. '#' with an empty entry commits 0.
- ENTRY_FULL = (count == MAX_DIGITS), registered.
- Maximum entry is 999,999,999, which fits in 30 bits, so no overflow handling is needed.
- Latency from a clean press to KEY_PULSE: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scans, plus 3 cycles.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2; a key is modelled as driving its row low while its column is low):
1. Assert RST for 2 cycles -> KEY_COL=110, KEY_CODE=F, ENTRY_VALUE=0, VALUE=0, VALID=0, KEY_PULSE=0. KEY_COL then cycles 110/101/011 every 4 cycles.
2. Press and release '1', '2', '3', each held 4 scans with 4 scans released between keys -> exactly 3 KEY_PULSEs with KEY_CODE 1, 2, 3; ENTRY_VALUE ends at 123.
3. Press '#' -> one-cycle VALID together with KEY_PULSE; VALUE=123; ENTRY_VALUE=0; holding '#' 10 more scans -> no further pulses.
4. Press '5' for 1 scan only, then alternate pressed/released every scan for 6 scans -> no KEY_PULSE; ENTRY_VALUE unchanged.
5. Press '9' nine times -> ENTRY_VALUE=99999999 and ENTRY_FULL=1 after the 8th press; the 9th press gives KEY_PULSE but no value change. Then '*' -> ENTRY_VALUE=0, ENTRY_FULL=0.
6. Hold '5' and '6' together for 5 scans -> no acceptance. Then enter '4', and pulse RST while '7' is being debounced -> ENTRY_VALUE=0 after reset; '7' is accepted only after a fresh full debounce.
